// File: rtl/wots_pkg.sv
// wots_pkg: shared WOTS constants, mode and sequencer-state encodings, the
// chain-address field position inside the hash address, and small helpers
// for digit extraction and per-chain step planning.
package wots_pkg;

  localparam int WOTS_W     = 16;
  localparam int WOTS_LOG_W = 4;
  localparam int WOTS_LEN1  = 64;
  localparam int WOTS_LEN2  = 3;
  localparam int WOTS_LEN   = WOTS_LEN1 + WOTS_LEN2;
  localparam int KEY_LEN    = 256;

  // Chain-address word inside the 256-bit hash address.
  localparam int CHAIN_ADDR_HI = 95;
  localparam int CHAIN_ADDR_LO = 64;

  localparam logic [6:0] LAST_CHAIN = 7'(WOTS_LEN - 1);

  typedef enum logic [1:0] {
    MODE_PKGEN  = 2'd0,
    MODE_SIGN   = 2'd1,
    MODE_VERIFY = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CSUM   = 3'd1,
    S_FETCH  = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_EMIT   = 3'd5,
    S_DONE   = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic       bypass;
    logic [3:0] start_step;
    logic [3:0] end_step;
  } chain_plan_t;

  // Base-w digit i of the message, most significant nibble first.
  function automatic logic [3:0] msg_digit(input logic [KEY_LEN-1:0] m, input logic [5:0] i);
    return m[(KEY_LEN - 1) - 4 * int'(i) -: 4];
  endfunction

  // Step window for one chain. A zero-step chain is bypassed; its end_step
  // is meaningless because gen_chain never sees it.
  function automatic chain_plan_t chain_plan(input mode_e m, input logic [3:0] d);
    chain_plan_t p;
    logic [3:0]  steps;
    case (m)
      MODE_SIGN: begin
        steps        = d;
        p.start_step = 4'd0;
      end
      MODE_VERIFY: begin
        steps        = 4'd15 - d;
        p.start_step = d;
      end
      default: begin
        steps        = 4'd15;
        p.start_step = 4'd0;
      end
    endcase
    p.bypass   = (steps == 4'd0);
    p.end_step = p.start_step + steps - 4'd1;
    return p;
  endfunction

endpackage

// File: rtl/wots_csum.sv
// wots_csum: latches the message digest on i_start, then accumulates the
// WOTS checksum serially (one digit per cycle, 64 cycles). Presents all 67
// base-w digits (64 message digits followed by 3 checksum digits) as a flat
// vector; digit i occupies o_digits[4i+3:4i].
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_start      load i_msg and restart the accumulation
//   i_msg        256-bit message digest
//   o_digits     67 x 4-bit digit vector
//   o_ready      checksum digits valid (held until the next i_start)
module wots_csum
  import wots_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic [KEY_LEN-1:0]        i_msg,
  output logic [WOTS_LEN*4-1:0]     o_digits,
  output logic                      o_ready
);

  logic [KEY_LEN-1:0] r_msg;
  logic [5:0]         r_cnt;
  logic [11:0]        r_csum;
  logic               r_run;
  logic               r_ready;
  logic [3:0]         w_cur;
  logic [15:0]        w_csum_sh;

  assign w_cur     = msg_digit(r_msg, r_cnt);
  assign w_csum_sh = {r_csum, 4'b0000};
  assign o_ready   = r_ready;

  // Serial accumulation of (15 - d_i); max 64*15 = 960 fits in 12 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_msg   <= '0;
      r_cnt   <= 6'd0;
      r_csum  <= 12'd0;
      r_run   <= 1'b0;
      r_ready <= 1'b0;
    end else if (i_start) begin
      r_msg   <= i_msg;
      r_cnt   <= 6'd0;
      r_csum  <= 12'd0;
      r_run   <= 1'b1;
      r_ready <= 1'b0;
    end else if (r_run) begin
      r_csum <= r_csum + {8'd0, 4'd15 - w_cur};
      r_cnt  <= r_cnt + 6'd1;
      if (r_cnt == 6'd63) begin
        r_run   <= 1'b0;
        r_ready <= 1'b1;
      end
    end
  end

  // Digit vector: message nibbles, then the left-shifted checksum nibbles.
  always_comb begin
    o_digits = '0;
    for (int i = 0; i < WOTS_LEN1; i++) begin
      o_digits[4*i +: 4] = msg_digit(r_msg, 6'(i));
    end
    for (int j = 0; j < WOTS_LEN2; j++) begin
      o_digits[4*(WOTS_LEN1 + j) +: 4] = w_csum_sh[15 - 4*j -: 4];
    end
  end

endmodule

// File: rtl/wots_chain_seq.sv
// wots_chain_seq: walks one WOTS key operation (PKGEN, SIGN, VERIFY) over
// chains 0..66, one chain in flight. For each chain it fetches the input
// element, derives the step window from the base-w digit, launches the
// external gen_chain (or bypasses it when zero steps are needed) and emits
// the chain result.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, mode           operation request (pulse) and operation type
//   msg, base_addr        digest and hash address template, sampled on start
//   in_req/in_idx         chain input request, answered by in_valid/in_data
//   out_valid/idx/data    chain result strobe
//   busy, done            operation status
//   gc_*                  gen_chain handshake (start, operands, done, result)
module wots_chain_seq
  import wots_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [KEY_LEN-1:0] msg,
  input  logic [KEY_LEN-1:0] base_addr,
  output logic               in_req,
  output logic [6:0]         in_idx,
  input  logic               in_valid,
  input  logic [KEY_LEN-1:0] in_data,
  output logic               out_valid,
  output logic [6:0]         out_idx,
  output logic [KEY_LEN-1:0] out_data,
  output logic               busy,
  output logic               done,
  output logic               gc_start,
  output logic [KEY_LEN-1:0] gc_input_data,
  output logic [3:0]         gc_start_step,
  output logic [3:0]         gc_end_step,
  output logic [KEY_LEN-1:0] gc_hash_addr,
  input  logic               gc_done,
  input  logic [KEY_LEN-1:0] gc_data_out
);

  seq_state_e                          r_state;
  seq_state_e                          w_next;
  mode_e                               r_mode;
  logic [KEY_LEN-1:CHAIN_ADDR_HI+1]    r_base_hi;
  logic [CHAIN_ADDR_LO-1:0]            r_base_lo;
  logic [6:0]                          r_k;
  logic [KEY_LEN-1:0]                  r_in_data;
  logic [KEY_LEN-1:0]                  r_out_data;
  logic                                r_bypass;
  logic [3:0]                          r_start_step;
  logic [3:0]                          r_end_step;
  logic                                r_in_req;
  logic                                r_out_valid;
  logic                                r_busy;
  logic                                r_done;
  logic                                r_gc_start;

  logic                                w_accept;
  logic [WOTS_LEN*4-1:0]               w_digits;
  logic                                w_csum_ready;
  logic [3:0]                          w_digit;
  chain_plan_t                         w_plan;
  logic                                w_unused_chain_field;

  // The chain-address word of the template is replaced by the chain index.
  assign w_unused_chain_field = ^base_addr[CHAIN_ADDR_HI:CHAIN_ADDR_LO];

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_digit  = w_digits[{r_k, 2'b00} +: 4];
  assign w_plan   = chain_plan(r_mode, w_digit);

  wots_csum u_csum (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_accept),
    .i_msg    (msg),
    .o_digits (w_digits),
    .o_ready  (w_csum_ready)
  );

  // Next-state logic of the chain sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((mode_e'(mode) == MODE_SIGN) || (mode_e'(mode) == MODE_VERIFY)) begin
            w_next = S_CSUM;
          end else begin
            w_next = S_FETCH;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CSUM: begin
        if (w_csum_ready) w_next = S_FETCH;
        else              w_next = S_CSUM;
      end
      S_FETCH: begin
        if (in_valid) w_next = S_LAUNCH;
        else          w_next = S_FETCH;
      end
      S_LAUNCH: begin
        if (r_bypass) w_next = S_EMIT;
        else          w_next = S_WAIT;
      end
      S_WAIT: begin
        if (gc_done) w_next = S_EMIT;
        else         w_next = S_WAIT;
      end
      S_EMIT: begin
        if (r_k == LAST_CHAIN) w_next = S_DONE;
        else                   w_next = S_FETCH;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, operand and strobe registers. Strobes are registered from the
  // next state so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mode       <= MODE_PKGEN;
      r_base_hi    <= '0;
      r_base_lo    <= '0;
      r_k          <= 7'd0;
      r_in_data    <= '0;
      r_out_data   <= '0;
      r_bypass     <= 1'b0;
      r_start_step <= 4'd0;
      r_end_step   <= 4'd0;
      r_in_req     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_gc_start   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_mode    <= (mode_e'(mode) == MODE_RSVD) ? MODE_PKGEN : mode_e'(mode);
        r_base_hi <= base_addr[KEY_LEN-1:CHAIN_ADDR_HI+1];
        r_base_lo <= base_addr[CHAIN_ADDR_LO-1:0];
        r_k       <= 7'd0;
      end

      // Operands are captured once per chain and then held through WAIT.
      if ((r_state == S_FETCH) && in_valid) begin
        r_in_data    <= in_data;
        r_bypass     <= w_plan.bypass;
        r_start_step <= w_plan.start_step;
        r_end_step   <= w_plan.end_step;
      end

      if ((r_state == S_LAUNCH) && r_bypass) begin
        r_out_data <= r_in_data;
      end else if ((r_state == S_WAIT) && gc_done) begin
        r_out_data <= gc_data_out;
      end

      if ((r_state == S_EMIT) && (r_k != LAST_CHAIN)) begin
        r_k <= r_k + 7'd1;
      end

      r_in_req    <= (w_next == S_FETCH);
      r_out_valid <= (w_next == S_EMIT);
      r_done      <= (w_next == S_DONE);
      r_busy      <= (w_next != S_IDLE) && (w_next != S_DONE);
      r_gc_start  <= (r_state == S_FETCH) && in_valid && !w_plan.bypass;
    end
  end

  assign in_req        = r_in_req;
  assign in_idx        = r_k;
  assign out_valid     = r_out_valid;
  assign out_idx       = r_k;
  assign out_data      = r_out_data;
  assign busy          = r_busy;
  assign done          = r_done;
  assign gc_start      = r_gc_start;
  assign gc_input_data = r_in_data;
  assign gc_start_step = r_start_step;
  assign gc_end_step   = r_end_step;
  assign gc_hash_addr  = {r_base_hi, 25'd0, r_k, r_base_lo};

endmodule

// File: tb/tb_wots_chain_seq.sv
module tb_wots_chain_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [255:0] msg = '0;
  logic [255:0] base_addr = '0;
  logic         in_req;
  logic [6:0]   in_idx;
  logic         in_valid = 1'b0;
  logic [255:0] in_data = '0;
  logic         out_valid;
  logic [6:0]   out_idx;
  logic [255:0] out_data;
  logic         busy;
  logic         done;
  logic         gc_start;
  logic [255:0] gc_input_data;
  logic [3:0]   gc_start_step;
  logic [3:0]   gc_end_step;
  logic [255:0] gc_hash_addr;
  logic         gc_done = 1'b0;
  logic [255:0] gc_data_out = '0;

  wots_chain_seq dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .msg(msg),
    .base_addr(base_addr), .in_req(in_req), .in_idx(in_idx),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
    .out_idx(out_idx), .out_data(out_data), .busy(busy), .done(done),
    .gc_start(gc_start), .gc_input_data(gc_input_data),
    .gc_start_step(gc_start_step), .gc_end_step(gc_end_step),
    .gc_hash_addr(gc_hash_addr), .gc_done(gc_done), .gc_data_out(gc_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   idx;
    logic [255:0] data;
  } out_exp_t;

  typedef struct {
    logic [6:0]   idx;
    logic [3:0]   s;
    logic [3:0]   e;
    logic [255:0] addr;
    logic [255:0] din;
  } launch_exp_t;

  out_exp_t    exp_q[$];
  launch_exp_t launch_q[$];

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_out_cyc = -10;
  int          done_cnt = 0;
  logic [31:0] cur_tag = 32'd0;
  bit          rand_dly = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [255:0] sk_val(input logic [31:0] tag, input logic [6:0] k);
    logic [31:0] w;
    w = tag ^ {25'd0, k};
    return {w, ~w, w + 32'd1, w ^ 32'h5A5A5A5A, tag, {25'd0, k}, 32'hC0FFEE00, w};
  endfunction

  // Chain input responder: answers in_req after 0..5 extra cycles.
  always begin
    @(negedge clk);
    if (in_req && !reset) begin
      if (rand_dly) repeat ($urandom_range(0, 5)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = sk_val(cur_tag, in_idx);
      @(negedge clk);
      in_valid = 1'b0;
    end
  end

  // gen_chain model: one hash per cycle; result tags input with addr/window.
  int           gc_cnt = 0;
  logic [255:0] cap_in, cap_addr;
  logic [3:0]   cap_s, cap_e;
  always @(negedge clk) begin
    launch_exp_t le;
    gc_done = 1'b0;
    if (reset) begin
      gc_cnt = 0;
    end else if (gc_cnt > 0) begin
      gc_cnt--;
      if (gc_cnt == 0) begin
        check("gc_operands_held",
              {255'd0, (gc_input_data === cap_in) && (gc_hash_addr === cap_addr) &&
                       (gc_start_step === cap_s) && (gc_end_step === cap_e)}, 256'd1);
        gc_data_out = cap_in ^ {cap_addr[95:64], 216'd0, cap_s, cap_e};
        gc_done     = 1'b1;
      end
    end else if (gc_start) begin
      if (launch_q.size() == 0) begin
        check("gc_start_unexpected", {249'd0, in_idx}, 256'h7F);
      end else begin
        le = launch_q.pop_front();
        check("gc_start_step", {252'd0, gc_start_step}, {252'd0, le.s});
        check("gc_end_step", {252'd0, gc_end_step}, {252'd0, le.e});
        check("gc_hash_addr", gc_hash_addr, le.addr);
        check("gc_input_data", gc_input_data, le.din);
      end
      cap_in   = gc_input_data;
      cap_addr = gc_hash_addr;
      cap_s    = gc_start_step;
      cap_e    = gc_end_step;
      gc_cnt   = int'(gc_end_step) - int'(gc_start_step) + 1;
      if (gc_cnt < 1) gc_cnt = 1;
    end
  end

  // Output monitor: pops the scoreboard on every out_valid, checks done timing.
  always @(negedge clk) begin
    out_exp_t oe;
    cyc++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", {249'd0, out_idx}, 256'h7F);
      end else begin
        oe = exp_q.pop_front();
        check("out_idx", {249'd0, out_idx}, {249'd0, oe.idx});
        check("out_data", out_data, oe.data);
      end
      last_out_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      check("done_after_last_out", 256'(cyc), 256'(last_out_cyc + 1));
      check("busy_low_at_done", {255'd0, busy}, 256'd0);
    end
  end

  task automatic plan_op(input logic [1:0] m, input logic [255:0] msg_v, input logic [255:0] base_v,
                         input logic [31:0] tag, input logic [3:0] c0, input logic [3:0] c1,
                         input logic [3:0] c2);
    logic [3:0]   d, st, steps, en;
    logic [255:0] sk, a;
    cur_tag = tag;
    for (int k = 0; k < 67; k++) begin
      if (k < 64)       d = msg_v[255 - 4*k -: 4];
      else if (k == 64) d = c0;
      else if (k == 65) d = c1;
      else              d = c2;
      if (m == 2'd1)      begin st = 4'd0; steps = d; end
      else if (m == 2'd2) begin st = d; steps = 4'd15 - d; end
      else                begin st = 4'd0; steps = 4'd15; end
      sk = sk_val(tag, 7'(k));
      a  = base_v;
      a[95:64] = 32'(k);
      if (steps == 4'd0) begin
        exp_q.push_back('{7'(k), sk});
      end else begin
        en = st + steps - 4'd1;
        exp_q.push_back('{7'(k), sk ^ {32'(k), 216'd0, st, en}});
        launch_q.push_back('{7'(k), st, en, a, sk});
      end
    end
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [255:0] msg_v, input logic [255:0] base_v);
    @(negedge clk);
    mode = m; msg = msg_v; base_addr = base_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {255'd0, busy}, 256'd1);
  endtask

  task automatic run_op(input logic [1:0] m, input logic [255:0] msg_v, input logic [255:0] base_v,
                        input logic [31:0] tag, input logic [3:0] c0, input logic [3:0] c1,
                        input logic [3:0] c2, input bit poke);
    int dc0;
    plan_op(m, msg_v, base_v, tag, c0, c1, c2);
    dc0 = done_cnt;
    pulse_start(m, msg_v, base_v);
    if (poke) begin
      repeat (10) @(negedge clk);
      mode = 2'd0; msg = ~msg_v; base_addr = ~base_v; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 6000 && done_cnt == dc0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_once", 256'(done_cnt - dc0), 256'd1);
    check("all_outputs_seen", 256'(exp_q.size()), 256'd0);
    check("all_launches_seen", 256'(launch_q.size()), 256'd0);
    exp_q.delete();
    launch_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, {255'd0, out_valid}, 256'd0);
    check({tag, "_done"}, {255'd0, done}, 256'd0);
    check({tag, "_busy"}, {255'd0, busy}, 256'd0);
    check({tag, "_in_req"}, {255'd0, in_req}, 256'd0);
    check({tag, "_gc_start"}, {255'd0, gc_start}, 256'd0);
    check({tag, "_out_data"}, out_data, 256'd0);
    check({tag, "_idx"}, {242'd0, out_idx, in_idx}, 256'd0);
    check({tag, "_gc_hash_addr"}, gc_hash_addr, 256'd0);
    check({tag, "_gc_input_data"}, gc_input_data, 256'd0);
    check({tag, "_gc_steps"}, {248'd0, gc_start_step, gc_end_step}, 256'd0);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [255:0] m0123, mzero, mf, base1, base2;
    bit           found;
    int           dc0;
    m0123 = {4{64'h0123456789ABCDEF}};
    mzero = '0;
    mf    = '1;
    base1 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001};
    base2 = {4{64'hFEDC_BA98_7654_3210}};

    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    reset = 1'b0;

    // PKGEN: every chain 0..14.
    run_op(2'd0, m0123 ^ base2, base1, 32'h1000_0000, 4'd0, 4'd0, 4'd0, 1'b0);
    // SIGN, all-zero digest: checksum 960 -> 3,C,0.
    run_op(2'd1, mzero, base2, 32'h2000_0000, 4'd3, 4'd12, 4'd0, 1'b0);
    // VERIFY, all-F digest: checksum 0.
    run_op(2'd2, mf, base1, 32'h3000_0000, 4'd0, 4'd0, 4'd0, 1'b0);
    // SIGN, 0123..EF: checksum 480 = 0x1E0 -> 1,E,0; random latency, start poked.
    rand_dly = 1'b1;
    run_op(2'd1, m0123, base1, 32'h4000_0000, 4'd1, 4'd14, 4'd0, 1'b1);
    // VERIFY, 0123..EF with the same checksum digits.
    run_op(2'd2, m0123, base2, 32'h5000_0000, 4'd1, 4'd14, 4'd0, 1'b1);
    // Reserved mode behaves as PKGEN.
    run_op(2'd3, m0123, base2, 32'h6000_0000, 4'd0, 4'd0, 4'd0, 1'b0);

    // Reset while chain 10 is in WAIT.
    rand_dly = 1'b0;
    plan_op(2'd1, m0123, base1, 32'h7000_0000, 4'd1, 4'd14, 4'd0);
    pulse_start(2'd1, m0123, base1);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (gc_start && in_idx == 7'd10) found = 1'b1;
    end
    check("reach_chain10", {255'd0, found}, 256'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 check_zero("midreset");
    reset = 1'b0;
    exp_q.delete();
    launch_q.delete();
    dc0 = done_cnt;
    repeat (30) @(negedge clk);
    check("no_done_after_reset", 256'(done_cnt - dc0), 256'd0);

    run_op(2'd0, mf, base2, 32'h8000_0000, 4'd0, 4'd0, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
